// File: rtl/ysyx_24100006_gpr_sb.sv
// General-purpose register file with a per-register pending-write scoreboard.
// Combinational read ports with optional writeback bypass; one writeback port.
module ysyx_24100006_gpr_sb #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NREAD      = 2,
    parameter int CNT_WIDTH  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREAD*ADDR_WIDTH-1:0]   raddr,
    output logic [NREAD*DATA_WIDTH-1:0]   rdata,
    output logic [NREAD-1:0]              rbusy,
    input  logic                          iss_valid,
    input  logic [ADDR_WIDTH-1:0]         iss_rd,
    output logic                          iss_ready,
    input  logic                          wb_valid,
    input  logic [ADDR_WIDTH-1:0]         wb_addr,
    input  logic [DATA_WIDTH-1:0]         wb_data,
    input  logic                          flush,
    output logic [2**ADDR_WIDTH-1:0]      busy_vec,
    output logic                          err_underflow
);
    localparam int NREG = 2**ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] rf_reg   [NREG];
    logic [CNT_WIDTH-1:0]  cnt_reg  [NREG];
    logic [CNT_WIDTH-1:0]  cnt_next [NREG];
    logic                  err_reg;

    logic wb_en;
    logic iss_acc;
    logic underflow;

    assign wb_en     = wb_valid && (wb_addr != '0);
    // Stall depends only on registered counts, never on a same-cycle writeback.
    assign iss_ready = !flush && !((iss_rd != '0) && (cnt_reg[iss_rd] == CNT_MAX));
    assign iss_acc   = iss_valid && iss_ready;
    assign underflow = wb_en && !flush && (cnt_reg[wb_addr] == '0)
                       && !(iss_acc && (iss_rd == wb_addr));
    assign err_underflow = err_reg;

    // Per-register counter next-state; x0 is never tracked.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
        if (gi == 0) begin : g_zero
            assign cnt_next[gi] = '0;
        end else begin : g_track
            logic inc;
            logic dec;
            assign inc = iss_acc && (iss_rd == ADDR_WIDTH'(gi));
            assign dec = wb_valid && (wb_addr == ADDR_WIDTH'(gi)) && (cnt_reg[gi] != '0);
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (flush)
                    cnt_next[gi] = '0;
                else if (inc && !dec)
                    cnt_next[gi] = cnt_reg[gi] + CNT_ONE;
                else if (dec && !inc)
                    cnt_next[gi] = cnt_reg[gi] - CNT_ONE;
            end
        end
        assign busy_vec[gi] = (cnt_reg[gi] != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                rf_reg[r]  <= '0;
                cnt_reg[r] <= '0;
            end
            err_reg <= 1'b0;
        end else begin
            if (wb_en)
                rf_reg[wb_addr] <= wb_data;
            for (int r = 0; r < NREG; r++)
                cnt_reg[r] <= cnt_next[r];
            if (underflow)
                err_reg <= 1'b1;
        end
    end

    // Read ports: a forwarded last pending write clears busy in the same cycle.
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        assign ra  = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = (BYPASS != 0) && wb_valid && (wb_addr == ra);
        assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
            (ra == '0) ? '0 : (hit ? wb_data : rf_reg[ra]);
        assign rbusy[gi] = (ra != '0) && (cnt_reg[ra] != '0)
                           && !(hit && (cnt_reg[ra] == CNT_ONE));
    end

endmodule

// File: tb/tb_ysyx_24100006_gpr_sb.sv
// Bench for ysyx_24100006_gpr_sb: directed scenarios plus randomized traffic
// checked against an integer-count scoreboard model.
module tb_ysyx_24100006_gpr_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [15:0] busy_vec;
    logic        err_underflow;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain integer pending counts, data array, sticky error.
    int          cnt_m [16];
    logic [31:0] rf_m  [16];
    bit          err_m;

    ysyx_24100006_gpr_sb dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
        .busy_vec(busy_vec), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic bit exp_ready();
        return !flush && !(iss_rd != 0 && cnt_m[iss_rd] == 3);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [3:0] a);
        if (a == 0) return 32'h0;
        if (wb_valid && wb_addr == a) return wb_data;
        return rf_m[a];
    endfunction

    function automatic bit exp_rbusy(input logic [3:0] a);
        int pend;
        if (a == 0) return 1'b0;
        pend = cnt_m[a] - ((wb_valid && wb_addr == a) ? 1 : 0);
        return pend > 0;
    endfunction

    function automatic logic [15:0] exp_busy_vec();
        logic [15:0] v;
        for (int r = 0; r < 16; r++) v[r] = (cnt_m[r] > 0);
        return v;
    endfunction

    task automatic idle();
        reset = 0; iss_valid = 0; iss_rd = 0; wb_valid = 0; wb_addr = 0;
        wb_data = 0; flush = 0;
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic tick();
        bit acc;
        int old [16];
        @(posedge clk);
        for (int r = 0; r < 16; r++) old[r] = cnt_m[r];
        if (reset) begin
            for (int r = 0; r < 16; r++) begin cnt_m[r] = 0; rf_m[r] = 0; end
            err_m = 0;
        end else begin
            acc = iss_valid && !flush && !(iss_rd != 0 && old[iss_rd] == 3);
            if (wb_valid && wb_addr != 0) rf_m[wb_addr] = wb_data;
            if (flush) begin
                for (int r = 0; r < 16; r++) cnt_m[r] = 0;
            end else begin
                if (acc && iss_rd != 0) cnt_m[iss_rd] = cnt_m[iss_rd] + 1;
                if (wb_valid && wb_addr != 0 && old[wb_addr] != 0)
                    cnt_m[wb_addr] = cnt_m[wb_addr] - 1;
                if (wb_valid && wb_addr != 0 && old[wb_addr] == 0 && !(acc && iss_rd == wb_addr))
                    err_m = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1; raddr = 0; tick(); idle(); #1;
        for (int a = 0; a < 16; a++) begin
            raddr = {a[3:0], a[3:0]}; #1;
            n_total++;
            if (rdata !== 64'h0 || rbusy !== 2'b00)
                $display("FAIL reset_read x%0d: rdata=%h rbusy=%b, want 0/00", a, rdata, rbusy);
            else n_pass++;
        end
        n_total++;
        if (busy_vec !== 16'h0 || iss_ready !== 1'b1 || err_underflow !== 1'b0)
            $display("FAIL reset_state: busy_vec=%h ready=%b err=%b, want 0000/1/0", busy_vec, iss_ready, err_underflow);
        else n_pass++;
    endtask

    task automatic test_bypass();
        idle(); iss_valid = 1; iss_rd = 5; tick();
        idle(); raddr = {4'd0, 4'd5}; #1;
        n_total++;
        if (rbusy[0] !== 1'b1 || busy_vec[5] !== 1'b1)
            $display("FAIL pending_x5: rbusy=%b busy_vec5=%b, want 1/1", rbusy[0], busy_vec[5]);
        else n_pass++;
        wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; #1;
        n_total++;
        if (rdata[31:0] !== 32'hDEADBEEF || rbusy[0] !== 1'b0)
            $display("FAIL bypass_x5: rdata=%h rbusy=%b, want deadbeef/0", rdata[31:0], rbusy[0]);
        else n_pass++;
        tick(); idle(); #1;
        n_total++;
        if (rdata[31:0] !== 32'hDEADBEEF || rbusy[0] !== 1'b0 || busy_vec[5] !== 1'b0)
            $display("FAIL after_wb_x5: rdata=%h rbusy=%b busy5=%b, want deadbeef/0/0", rdata[31:0], rbusy[0], busy_vec[5]);
        else n_pass++;
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 3; k++) begin
            idle(); iss_valid = 1; iss_rd = 3; #1;
            n_total++;
            if (iss_ready !== 1'b1) $display("FAIL sat_issue%0d: ready=%b, want 1", k, iss_ready);
            else n_pass++;
            tick();
        end
        idle(); iss_valid = 1; iss_rd = 3; #1;
        n_total++;
        if (iss_ready !== 1'b0) $display("FAIL sat_stall: ready=%b, want 0", iss_ready);
        else n_pass++;
        tick();
        wb_valid = 1; wb_addr = 3; wb_data = 32'h33; #1;
        n_total++;
        if (iss_ready !== 1'b0) $display("FAIL sat_no_wb_dep: ready=%b, want 0", iss_ready);
        else n_pass++;
        wb_valid = 0; iss_valid = 0; wb_valid = 1; tick();
        // cnt now 2: simultaneous issue and writeback keep it at 2
        idle(); iss_valid = 1; iss_rd = 3; wb_valid = 1; wb_addr = 3; wb_data = 32'h34; tick();
        idle(); iss_valid = 1; iss_rd = 3; #1;
        n_total++;
        if (iss_ready !== 1'b1) $display("FAIL sat_cnt2: ready=%b, want 1", iss_ready);
        else n_pass++;
        tick();
        idle(); iss_valid = 1; iss_rd = 3; #1;
        n_total++;
        if (iss_ready !== 1'b0) $display("FAIL sat_cnt3: ready=%b, want 0", iss_ready);
        else n_pass++;
        idle();
        for (int k = 0; k < 3; k++) begin
            wb_valid = 1; wb_addr = 3; wb_data = 32'h40 + k; tick();
        end
        idle(); raddr = {4'd3, 4'd3}; #1;
        n_total++;
        if (busy_vec[3] !== 1'b0 || err_underflow !== 1'b0 || rdata[63:32] !== 32'h42)
            $display("FAIL sat_drain: busy3=%b err=%b rdata=%h, want 0/0/00000042", busy_vec[3], err_underflow, rdata[63:32]);
        else n_pass++;
    endtask

    task automatic test_x0();
        idle(); iss_valid = 1; iss_rd = 0; wb_valid = 1; wb_addr = 0; wb_data = 32'h1234;
        raddr = 8'h00; #1;
        n_total++;
        if (rdata !== 64'h0 || rbusy !== 2'b00 || iss_ready !== 1'b1)
            $display("FAIL x0_same_cycle: rdata=%h rbusy=%b ready=%b, want 0/00/1", rdata, rbusy, iss_ready);
        else n_pass++;
        tick(); idle(); #1;
        n_total++;
        if (rdata !== 64'h0 || busy_vec !== 16'h0 || err_underflow !== 1'b0)
            $display("FAIL x0_after: rdata=%h busy_vec=%h err=%b, want 0/0000/0", rdata, busy_vec, err_underflow);
        else n_pass++;
    endtask

    task automatic test_flush();
        idle(); iss_valid = 1; iss_rd = 7; tick();
        idle(); iss_valid = 1; iss_rd = 9; tick();
        idle(); iss_valid = 1; iss_rd = 2; flush = 1;
        wb_valid = 1; wb_addr = 7; wb_data = 32'h55; #1;
        n_total++;
        if (iss_ready !== 1'b0) $display("FAIL flush_blocks_issue: ready=%b, want 0", iss_ready);
        else n_pass++;
        tick(); idle(); raddr = {4'd9, 4'd7}; #1;
        n_total++;
        if (busy_vec !== 16'h0 || rdata[31:0] !== 32'h55 || err_underflow !== 1'b0)
            $display("FAIL flush_state: busy_vec=%h x7=%h err=%b, want 0000/00000055/0", busy_vec, rdata[31:0], err_underflow);
        else n_pass++;
        wb_valid = 1; wb_addr = 9; wb_data = 32'h99; tick();
        idle(); #1;
        n_total++;
        if (err_underflow !== 1'b1 || rdata[63:32] !== 32'h99)
            $display("FAIL underflow_set: err=%b x9=%h, want 1/00000099", err_underflow, rdata[63:32]);
        else n_pass++;
        tick(); tick(); tick();
        n_total++;
        if (err_underflow !== 1'b1) $display("FAIL underflow_sticky: err=%b, want 1", err_underflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle(); iss_valid = 1; iss_rd = 4; tick(); tick(); tick();
        idle(); wb_valid = 1; wb_addr = 4; wb_data = 32'hA5; tick();
        idle(); raddr = {4'd4, 4'd4}; #1;
        n_total++;
        if (busy_vec[4] !== 1'b1 || rdata[31:0] !== 32'hA5)
            $display("FAIL pre_reset_x4: busy4=%b rdata=%h, want 1/000000a5", busy_vec[4], rdata[31:0]);
        else n_pass++;
        reset = 1; tick(); idle(); #1;
        n_total++;
        if (busy_vec !== 16'h0 || rdata !== 64'h0 || err_underflow !== 1'b0)
            $display("FAIL reset_mid: busy_vec=%h rdata=%h err=%b, want 0/0/0", busy_vec, rdata, err_underflow);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] a0, a1;
        for (int i = 0; i < 400; i++) begin
            idle();
            reset     = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            iss_valid = $urandom_range(0, 1);
            iss_rd    = 4'($urandom_range(0, 15));
            wb_valid  = $urandom_range(0, 1);
            wb_addr   = 4'($urandom_range(0, 15));
            wb_data   = $urandom;
            a0 = 4'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? wb_addr : 4'($urandom_range(0, 15));
            raddr = {a1, a0}; #1;
            n_total++;
            if (rdata !== {exp_rdata(a1), exp_rdata(a0)} || rbusy !== {exp_rbusy(a1), exp_rbusy(a0)}
                || iss_ready !== exp_ready() || busy_vec !== exp_busy_vec() || err_underflow !== err_m)
                $display("FAIL rand%0d: rdata=%h rbusy=%b ready=%b busy_vec=%h err=%b, want %h/%b/%b/%h/%b",
                         i, rdata, rbusy, iss_ready, busy_vec, err_underflow,
                         {exp_rdata(a1), exp_rdata(a0)}, {exp_rbusy(a1), exp_rbusy(a0)},
                         exp_ready(), exp_busy_vec(), err_m);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin cnt_m[r] = 0; rf_m[r] = 0; end
        err_m = 0;
        idle(); raddr = 0;
        test_reset();
        test_bypass();
        test_saturate();
        test_x0();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ysyx_24100006_gpr_sb.md
Name: ysyx_24100006_gpr_sb

Overview:
Parametrised general-purpose register file with an integrated write-pending scoreboard, for the pipelined core. It provides NREAD combinational read ports and one writeback port, with optional writeback-to-read bypass. Per-register pending counters let decode detect RAW hazards and stall. It sits in ID: reads and issue come from decode, the write port from WB, and flush from the redirect logic.

Parameters:
ADDR_WIDTH, 4, register index width; 2**ADDR_WIDTH registers (16 = RV32E).
DATA_WIDTH, 32, register width.
NREAD, 2, number of read ports (1..4).
CNT_WIDTH, 2, pending-counter width; MAX = 2**CNT_WIDTH-1 in-flight writes per register.
BYPASS, 1, 1 = same-cycle writeback forwarding to read ports; 0 = none.

Ports:
clk  in  1  clock, all state updates on posedge.
reset  in  1  synchronous, active-high reset.
raddr  in  NREAD*ADDR_WIDTH  read addresses; port i is bits [i*ADDR_WIDTH +: ADDR_WIDTH].
rdata  out  NREAD*DATA_WIDTH  read data, packed the same way.
rbusy  out  NREAD  1 = port i register has an outstanding write; value is not yet valid.
iss_valid  in  1  decode issues an instruction that will write iss_rd.
iss_rd  in  ADDR_WIDTH  destination of the issued instruction.
iss_ready  out  1  issue accepted this cycle when iss_valid && iss_ready.
wb_valid  in  1  writeback strobe.
wb_addr  in  ADDR_WIDTH  writeback destination.
wb_data  in  DATA_WIDTH  writeback data.
flush  in  1  pipeline flush; discard all pending-write tracking.
busy_vec  out  2**ADDR_WIDTH  bit r = (cnt[r] != 0), registered view.
err_underflow  out  1  sticky: writeback arrived with the target counter already 0.

Behaviour:
- State: rf[r] (DATA_WIDTH) and cnt[r] (CNT_WIDTH) for each register; err flag.
- Reset (sync, highest priority): all rf = 0, all cnt = 0, err_underflow = 0. Consequently busy_vec = 0, rbusy = 0, rdata = 0, iss_ready = 1 after reset.
- Register x0:
  - Reads always return 0 and never report busy.
  - Writes to x0 are dropped.
  - Issues to x0 are always accepted and do not touch any counter.
- Read path is combinational, zero latency:
  - rdata_i = rf[raddr_i].
  - If BYPASS=1 and wb_valid && wb_addr == raddr_i != 0, then rdata_i = wb_data.
- rbusy_i, with hit = (BYPASS && wb_valid && wb_addr == raddr_i):
  - BYPASS=0: rbusy_i = (cnt[raddr_i] != 0).
  - BYPASS=1: rbusy_i = (cnt[raddr_i] - hit) != 0, i.e. the last pending write completing this cycle clears busy in the same cycle.
- iss_ready = !flush && !(iss_rd != 0 && cnt[iss_rd] == MAX). It does not depend on a same-cycle writeback. When iss_ready = 0, issue stalls and no state changes.
- Write: on posedge, if wb_valid && wb_addr != 0, rf[wb_addr] <= wb_data. This also applies during flush.
- Counter update per register r, evaluated each posedge:
  - inc = accepted issue with iss_rd == r != 0.
  - dec = wb_valid && wb_addr == r != 0 && cnt[r] != 0.
  - inc && dec: cnt unchanged. inc only: +1. dec only: -1.
- Underflow: wb_valid to a nonzero register with cnt == 0 and no same-cycle inc. Data is still written, cnt stays 0, and err_underflow is set until reset.
- Flush: on posedge all cnt <= 0. A same-cycle issue is blocked because iss_ready = 0. A same-cycle writeback still writes data and does not raise err.
- Reset asserted mid-operation: all in-flight tracking is lost, with no error flagged.
- busy_vec is derived from the cnt registers and reflects state after the last edge; it does not include bypass.

Test Plan:
- Reset, then read x0..x15 on both ports -> rdata all 0, rbusy 0, busy_vec 0, iss_ready 1.
- Issue rd=5; next cycle read x5 -> rbusy=1, busy_vec[5]=1. Then wb x5=0xDEADBEEF -> same cycle rdata=0xDEADBEEF, rbusy=0 (BYPASS=1). Next cycle cnt[5]=0 and rf holds the value. With BYPASS=0: old value and rbusy=1 that cycle.
- Issue rd=3 three times (MAX=3) -> iss_ready=0 on the 4th attempt and cnt stays 3. A cycle with issue rd=3 and wb x3 together while cnt=2 -> cnt remains 2.
- Issue rd=0 and wb x0=0x1234 -> x0 reads 0, never busy, err_underflow=0.
- Issue rd=7 and rd=9, then flush with same-cycle wb x7=0x55 -> busy_vec=0, x7=0x55, err=0. A later wb x9 -> err_underflow=1 and stays 1 until reset.
- Assert reset with cnt[4]=2 and rf[4]=0xA5 -> next cycle cnt=0, rf[4]=0, err=0.
